sumador_acumulador_sat: RTL and testbench
=========================================

Name: sumador_acumulador_sat

Overview:
Sequential saturating accumulator for the FIR datapath. It sums exactly N_TERMS signed products per output sample using two's-complement saturation at every step, then presents the sample with a one-cycle valid pulse. It sits between the tap multipliers and the output register of the filter, and replaces chains of combinational saturating adders with a single time-multiplexed adder.

Parameters:
largo, 24, MSB index; data and result width is largo+1 bits, signed
N_TERMS, 8, terms accumulated per output sample; legal range is 1 or more
CW, $clog2(N_TERMS+1), term-counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
inicio  input  1  start a new accumulation; sampled only in IDLE
dato  input  largo+1  signed term
dato_valido  input  1  dato is valid this cycle
listo  output  1  block accepts dato this cycle
ocupado  output  1  accumulation in progress (ACUM or SALIDA)
y  output  largo+1  signed saturated sum
y_valido  output  1  one-cycle pulse; y is a new result
sat  output  1  at least one saturation occurred in the current or last accumulation

Behaviour:
- Reset (synchronous, active-high) clears the state to IDLE, the accumulator to 0, the counter to 0, and drives y=0, y_valido=0, sat=0, listo=0, ocupado=0.
- States: IDLE, ACUM, SALIDA.
- IDLE, with inicio=1: the accumulator clears to 0, the counter clears to 0, sat clears to 0, and the state moves to ACUM. Any dato_valido in the same cycle is ignored, because listo=0.
- ACUM: listo=1. A term is accepted only when dato_valido=1 and listo=1. On acceptance, acc <= sat_add(acc, dato) and the counter increments. If dato_valido=0, the block holds state with no timeout.
- ACUM to SALIDA happens on the cycle the N_TERMS-th term is accepted.
- SALIDA lasts exactly one cycle. In it, y = final acc (registered), y_valido=1 and listo=0, and the state then returns to IDLE.
- Latency: y_valido is asserted on the cycle after the last term is accepted. Minimum sample period is N_TERMS+2 cycles, counting the inicio cycle.
- inicio is ignored in ACUM and SALIDA.
- y holds its last value until the next SALIDA. sat holds until the next inicio.
- sat_add: the sum is computed at largo+2 bits. Overflow exists when both operands have the same sign and the sum's sign differs.
  - Positive overflow clamps to {0, all 1s} (max positive).
  - Negative overflow clamps to {1, all 0s} (most negative).
  - Any overflow sets sat=1.
- Saturation is not a permanent clamp: later terms are added to the clamped value, still with saturation.
- If reset is asserted mid-accumulation, the partial sum is discarded, the block returns to IDLE and no y_valido is produced.
- With N_TERMS=1, a single accepted term goes straight to SALIDA.

Optional Feature:
- Macro: SUMADOR_CONTSAT_EN.
- When defined: adds output cont_sat [15:0], which counts saturation events in the current accumulation. It clears on inicio, holds at 16'hFFFF when full, and is reset to 0.
- When undefined: the port and counter are absent, and sat is the only overflow indication.

Decomposition:
- Shared package/include holds:
  - the state encodings IDLE=2'd0, ACUM=2'd1, SALIDA=2'd2;
  - the MAX_POS and MIN_NEG constant functions of largo.
- One natural sub-module: sumador_sat. It is purely combinational (a, b in; y, ovf out, largo+1 bits) and is instantiated once for the accumulator update.

Test Plan:
- largo=7, N_TERMS=4. Feed inicio, then 10, 20, -5, 7 back-to-back. Expect y=32, sat=0, and y_valido high for exactly 1 cycle, on the cycle after -5's successor 7 is accepted.
- Terms 100, 100, 0, 0 -> y=127, sat=1. Terms -100, -100, 0, 0 -> y=-128, sat=1.
- Terms 127, 1, -1, 0 -> after the clamp to 127 the sum continues, giving y=126 with sat=1 still set.
- Toggle dato_valido low between every term (3 idle gaps) with terms 1, 2, 3, 4 -> y=10. Only accepted terms are counted, and y_valido fires once.
- Assert reset after 2 of 4 terms -> the next cycle shows IDLE with y=0, listo=0 and sat=0, and no y_valido follows. A fresh run with 1, 1, 1, 1 gives y=4.
- inicio pulsed during ACUM is ignored: the sum is unaffected. With SUMADOR_CONTSAT_EN, terms 127, 127, -128, -128 (largo=7) -> cont_sat=2.

Source files
------------

// File: rtl/sumador_acumulador_sat_pkg.sv
// ---------------------------------------------------------------------------
// sumador_acumulador_sat_pkg
// Shared definitions for the saturating accumulator:
//   - estado_t : FSM state encoding (IDLE, ACUM, SALIDA)
//   - max_pos  : largest positive value of a (largo+1)-bit signed word
//   - min_neg  : most negative value of a (largo+1)-bit signed word
// ---------------------------------------------------------------------------
package sumador_acumulador_sat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACUM   = 2'd1,
        SALIDA = 2'd2
    } estado_t;

    // Computed at 64 bits; callers size-cast to largo+1 bits.
    function automatic longint max_pos(input int largo);
        return (longint'(1) << largo) - longint'(1);
    endfunction

    function automatic longint min_neg(input int largo);
        return -(longint'(1) << largo);
    endfunction

endpackage

// File: rtl/sumador_acumulador_sat_sumador_sat.sv
// ---------------------------------------------------------------------------
// sumador_sat
// Combinational two's-complement saturating adder.
//   a, b : signed operands, largo+1 bits
//   y    : a+b clamped to [min_neg, max_pos]
//   ovf  : 1 when the true sum did not fit and y was clamped
// ---------------------------------------------------------------------------
module sumador_sat
    import sumador_acumulador_sat_pkg::*;
#(
    parameter int largo = 24
) (
    input  logic signed [largo:0] a,
    input  logic signed [largo:0] b,
    output logic signed [largo:0] y,
    output logic                  ovf
);

    localparam logic signed [largo:0] MAXP = (largo+1)'(max_pos(largo));
    localparam logic signed [largo:0] MINN = (largo+1)'(min_neg(largo));

    // One guard bit: the sign-extended sum always holds the exact result.
    logic [largo+1:0] s;

    assign s = {a[largo], a} + {b[largo], b};

    // Overflow only possible when operands share a sign; it shows up as the
    // in-range sign bit disagreeing with that shared sign.
    assign ovf = (a[largo] == b[largo]) && (s[largo] != a[largo]);

    assign y = !ovf      ? $signed(s[largo:0]) :
               a[largo]  ? MINN                : MAXP;

endmodule

// File: rtl/sumador_acumulador_sat.sv
// ---------------------------------------------------------------------------
// sumador_acumulador_sat
// Time-multiplexed saturating accumulator: sums exactly N_TERMS signed terms
// per sample with saturation at every step, then presents the result with a
// one-cycle y_valido pulse.
//
// Optional build macro: SUMADOR_CONTSAT_EN adds cont_sat[15:0], a sticky
// count of saturation events in the current accumulation.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   inicio      : start accumulation (sampled only in IDLE)
//   dato        : signed term, largo+1 bits
//   dato_valido : dato valid this cycle
//   listo       : block accepts dato this cycle
//   ocupado     : accumulation in progress (ACUM or SALIDA)
//   y           : saturated sum, held until next result
//   y_valido    : one-cycle pulse, y is new
//   sat         : saturation seen in current/last accumulation
//   cont_sat    : (SUMADOR_CONTSAT_EN only) saturation event count
// ---------------------------------------------------------------------------
module sumador_acumulador_sat
    import sumador_acumulador_sat_pkg::*;
#(
    parameter int largo   = 24,
    parameter int N_TERMS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic signed [largo:0] dato,
    input  logic                  dato_valido,
    output logic                  listo,
    output logic                  ocupado,
    output logic signed [largo:0] y,
    output logic                  y_valido,
`ifdef SUMADOR_CONTSAT_EN
    output logic [15:0]           cont_sat,
`endif
    output logic                  sat
);

    localparam int              CW     = $clog2(N_TERMS + 1);
    localparam logic [CW-1:0]   ULTIMO = CW'(N_TERMS - 1);

    estado_t               estado;
    logic signed [largo:0] acc;
    logic signed [largo:0] suma;
    logic                  ovf;
    logic [CW-1:0]         cnt;
    logic                  acepta;

    // listo is registered and high only in ACUM, so this is the handshake.
    assign acepta = (estado == ACUM) && listo && dato_valido;

    sumador_sat #(.largo(largo)) u_sumador_sat (
        .a   (acc),
        .b   (dato),
        .y   (suma),
        .ovf (ovf)
    );

    // NOTE: every register here uses non-blocking assignment so all state
    // updates within a cycle see the pre-edge values, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            y        <= '0;
            y_valido <= 1'b0;
            sat      <= 1'b0;
            listo    <= 1'b0;
            ocupado  <= 1'b0;
`ifdef SUMADOR_CONTSAT_EN
            cont_sat <= '0;
`endif
        end else begin
            case (estado)
                IDLE: begin
                    y_valido <= 1'b0;
                    if (inicio) begin
                        acc     <= '0;
                        cnt     <= '0;
                        sat     <= 1'b0;
                        listo   <= 1'b1;
                        ocupado <= 1'b1;
                        estado  <= ACUM;
`ifdef SUMADOR_CONTSAT_EN
                        cont_sat <= '0;
`endif
                    end
                end

                ACUM: begin
                    if (acepta) begin
                        acc <= suma;
                        cnt <= cnt + 1'b1;
                        if (ovf) begin
                            sat <= 1'b1;
`ifdef SUMADOR_CONTSAT_EN
                            if (cont_sat != 16'hFFFF)
                                cont_sat <= cont_sat + 16'd1;
`endif
                        end
                        // Last term: publish the updated sum directly so
                        // y is valid during the single SALIDA cycle.
                        if (cnt == ULTIMO) begin
                            y        <= suma;
                            y_valido <= 1'b1;
                            listo    <= 1'b0;
                            estado   <= SALIDA;
                        end
                    end
                end

                SALIDA: begin
                    y_valido <= 1'b0;
                    ocupado  <= 1'b0;
                    estado   <= IDLE;
                end

                default: begin
                    y_valido <= 1'b0;
                    listo    <= 1'b0;
                    ocupado  <= 1'b0;
                    estado   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_acumulador_sat.sv
// ---------------------------------------------------------------------------
// tb_sumador_acumulador_sat
// Directed self-checking bench for sumador_acumulador_sat (largo=7,
// N_TERMS=4). Inputs change 1 ns after the rising edge; outputs are checked
// at the same point, reflecting the registers updated by that edge.
// ---------------------------------------------------------------------------
module tb_sumador_acumulador_sat;

    localparam int LARGO   = 7;
    localparam int N_TERMS = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  inicio;
    logic signed [LARGO:0] dato;
    logic                  dato_valido;
    logic                  listo;
    logic                  ocupado;
    logic signed [LARGO:0] y;
    logic                  y_valido;
    logic                  sat;
`ifdef SUMADOR_CONTSAT_EN
    logic [15:0]           cont_sat;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sumador_acumulador_sat #(.largo(LARGO), .N_TERMS(N_TERMS)) dut (
        .clk         (clk),
        .reset       (reset),
        .inicio      (inicio),
        .dato        (dato),
        .dato_valido (dato_valido),
        .listo       (listo),
        .ocupado     (ocupado),
        .y           (y),
        .y_valido    (y_valido),
`ifdef SUMADOR_CONTSAT_EN
        .cont_sat    (cont_sat),
`endif
        .sat         (sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // inicio cycle, with a stray valid term that must be ignored.
    task automatic start();
        inicio      = 1'b1;
        dato        = 8'sd50;
        dato_valido = 1'b1;
        step();
        inicio      = 1'b0;
        dato_valido = 1'b0;
        check("start_listo", int'(listo), 1);
        check("start_ocupado", int'(ocupado), 1);
    endtask

    // Runs one full sample of four terms; with gaps, dato_valido drops for
    // one cycle between terms.
    task automatic run(input string tag, input int t0, input int t1,
                       input int t2, input int t3, input bit gaps,
                       input int exp_y, input int exp_sat);
        int t[4];
        t = '{t0, t1, t2, t3};
        start();
        for (int i = 0; i < 4; i++) begin
            dato        = 8'(t[i]);
            dato_valido = 1'b1;
            step();
            dato_valido = 1'b0;
            if (i < 3) begin
                check({tag, "_novalid"}, int'(y_valido), 0);
                if (gaps) begin
                    step();
                    check({tag, "_gap_listo"}, int'(listo), 1);
                    check({tag, "_gap_novalid"}, int'(y_valido), 0);
                end
            end
        end
        check({tag, "_y_valido"}, int'(y_valido), 1);
        check({tag, "_y"}, int'(y), exp_y);
        check({tag, "_sat"}, int'(sat), exp_sat);
        check({tag, "_listo_salida"}, int'(listo), 0);
        check({tag, "_ocupado_salida"}, int'(ocupado), 1);
        step();
        check({tag, "_pulse_end"}, int'(y_valido), 0);
        check({tag, "_idle_ocupado"}, int'(ocupado), 0);
        check({tag, "_y_hold"}, int'(y), exp_y);
        check({tag, "_sat_hold"}, int'(sat), exp_sat);
    endtask

    initial begin
        reset       = 1'b1;
        inicio      = 1'b0;
        dato        = '0;
        dato_valido = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_listo", int'(listo), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_y", int'(y), 0);
        check("rst_y_valido", int'(y_valido), 0);
        check("rst_sat", int'(sat), 0);
`ifdef SUMADOR_CONTSAT_EN
        check("rst_cont_sat", int'(cont_sat), 0);
`endif
        step();

        run("basic",   10,   20,  -5, 7, 1'b0,   32, 0);
        run("pos_sat", 100,  100,  0, 0, 1'b0,  127, 1);
        run("neg_sat", -100, -100, 0, 0, 1'b0, -128, 1);
        run("resume",  127,  1,   -1, 0, 1'b0,  126, 1);
        run("gaps",    1,    2,    3, 4, 1'b1,   10, 0);

        // Reset mid-accumulation after two saturating terms.
        start();
        dato = 8'sd127; dato_valido = 1'b1; step();
        dato = 8'sd127; step();
        dato_valido = 1'b0;
        check("mid_sat_set", int'(sat), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_listo", int'(listo), 0);
        check("midrst_ocupado", int'(ocupado), 0);
        check("midrst_y", int'(y), 0);
        check("midrst_sat", int'(sat), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_valid", int'(y_valido), 0);
        end

        // Fresh run of ones, with inicio pulsed mid-ACUM (must be ignored).
        start();
        dato = 8'sd1; dato_valido = 1'b1; step();
        step();
        dato_valido = 1'b0;
        inicio      = 1'b1;
        step();
        inicio      = 1'b0;
        check("ini_ign_listo", int'(listo), 1);
        dato_valido = 1'b1; step();
        step();
        dato_valido = 1'b0;
        check("ones_valid", int'(y_valido), 1);
        check("ones_y", int'(y), 4);
        check("ones_sat", int'(sat), 0);
        step();
        check("ones_pulse_end", int'(y_valido), 0);

        // Two saturations: 127+127 -> 127, -1, -1-128 -> -128.
        run("two_sat", 127, 127, -128, -128, 1'b0, -128, 1);
`ifdef SUMADOR_CONTSAT_EN
        check("cont_sat_two", int'(cont_sat), 2);
        run("no_sat", 1, 1, 1, 1, 1'b0, 4, 0);
        check("cont_sat_clear", int'(cont_sat), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
